// File: rtl/spu_pkg.sv
// Shared types and constants for the dual-issue scheduler and its register scoreboard.
package spu_pkg;

    localparam int REG_ADDR_W = 7;
    localparam int NUM_REGS   = 128;
    localparam int LAT_W      = 4;
    localparam int NUM_LOOKUP = 8;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [LAT_W-1:0]      lat_t;

    typedef enum logic {
        S_PAIR   = 1'b0,
        S_SECOND = 1'b1
    } issue_state_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register latency counters with two issue write ports and eight combinational count lookups.
module reg_scoreboard
    import spu_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      i_we1,
    input  reg_addr_t i_waddr1,
    input  lat_t      i_wlat1,
    input  logic      i_we2,
    input  reg_addr_t i_waddr2,
    input  lat_t      i_wlat2,
    input  reg_addr_t i_lookup [NUM_LOOKUP],
    output lat_t      o_count  [NUM_LOOKUP]
);

    lat_t r_cnt [NUM_REGS];

    // A fresh write overrides the countdown; a zero latency is a no-op write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_cnt[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (i_we2 && (i_waddr2 == reg_addr_t'(r)) && (i_wlat2 != '0)) begin
                    r_cnt[r] <= i_wlat2;
                end else if (i_we1 && (i_waddr1 == reg_addr_t'(r)) && (i_wlat1 != '0)) begin
                    r_cnt[r] <= i_wlat1;
                end else if (r_cnt[r] != '0) begin
                    r_cnt[r] <= r_cnt[r] - lat_t'(1);
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_LOOKUP; i++) begin
            o_count[i] = r_cnt[i_lookup[i]];
        end
    end

endmodule

// File: rtl/dual_issue_scheduler.sv
// Decides each cycle which decoded slots issue to the even/odd pipes, stalling on scoreboard hazards.
module dual_issue_scheduler
    import spu_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      flush,
    input  logic      pair_valid,
    input  logic      valid2,
    input  logic      isEven1,
    input  logic      isEven2,
    input  reg_addr_t readRegisterRA1,
    input  reg_addr_t readRegisterRB1,
    input  reg_addr_t readRegisterRC1,
    input  reg_addr_t readRegisterRT1,
    input  reg_addr_t readRegisterRA2,
    input  reg_addr_t readRegisterRB2,
    input  reg_addr_t readRegisterRC2,
    input  reg_addr_t readRegisterRT2,
    input  logic      useRA1,
    input  logic      useRB1,
    input  logic      useRC1,
    input  logic      useRA2,
    input  logic      useRB2,
    input  logic      useRC2,
    input  logic      regWriteEnable1,
    input  logic      regWriteEnable2,
    input  lat_t      latency1,
    input  lat_t      latency2,
    output logic      pair_ready,
    output logic      issue_even_valid,
    output logic      issue_even_slot,
    output logic      issue_odd_valid,
    output logic      issue_odd_slot,
    output logic      stall
);

    issue_state_t r_state;
    issue_state_t w_next_state;

    reg_addr_t w_lookup [NUM_LOOKUP];
    lat_t      w_count  [NUM_LOOKUP];
    logic      w_issue1;
    logic      w_issue2;
    logic      w_hz1;
    logic      w_hz2;
    logic      w_raw;
    logic      w_dual_ok;

    assign w_lookup[0] = readRegisterRA1;
    assign w_lookup[1] = readRegisterRB1;
    assign w_lookup[2] = readRegisterRC1;
    assign w_lookup[3] = readRegisterRT1;
    assign w_lookup[4] = readRegisterRA2;
    assign w_lookup[5] = readRegisterRB2;
    assign w_lookup[6] = readRegisterRC2;
    assign w_lookup[7] = readRegisterRT2;

    reg_scoreboard u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_we1    (w_issue1 && regWriteEnable1),
        .i_waddr1 (readRegisterRT1),
        .i_wlat1  (latency1),
        .i_we2    (w_issue2 && regWriteEnable2),
        .i_waddr2 (readRegisterRT2),
        .i_wlat2  (latency2),
        .i_lookup (w_lookup),
        .o_count  (w_count)
    );

    // A writer may not finish before an older pending write to the same target.
    assign w_hz1 = (!useRA1 || (w_count[0] == '0)) &&
                   (!useRB1 || (w_count[1] == '0)) &&
                   (!useRC1 || (w_count[2] == '0)) &&
                   (!regWriteEnable1 || (w_count[3] <= latency1));

    assign w_hz2 = (!useRA2 || (w_count[4] == '0)) &&
                   (!useRB2 || (w_count[5] == '0)) &&
                   (!useRC2 || (w_count[6] == '0)) &&
                   (!regWriteEnable2 || (w_count[7] <= latency2));

    assign w_raw = regWriteEnable1 &&
                   ((useRA2 && (readRegisterRA2 == readRegisterRT1)) ||
                    (useRB2 && (readRegisterRB2 == readRegisterRT1)) ||
                    (useRC2 && (readRegisterRC2 == readRegisterRT1)));

    assign w_dual_ok = valid2 && w_hz1 && w_hz2 && (isEven1 != isEven2) && !w_raw &&
                       !(regWriteEnable1 && regWriteEnable2 && (readRegisterRT1 == readRegisterRT2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_PAIR;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Issue decision; flush pre-empts any issue so no scoreboard write can land.
    always_comb begin
        w_next_state = r_state;
        w_issue1     = 1'b0;
        w_issue2     = 1'b0;
        pair_ready   = 1'b0;
        stall        = 1'b0;
        if (!rst_n) begin
            w_next_state = S_PAIR;
        end else if (flush) begin
            w_next_state = S_PAIR;
            pair_ready   = 1'b1;
        end else if (pair_valid) begin
            case (r_state)
                S_PAIR: begin
                    if (w_dual_ok) begin
                        w_issue1   = 1'b1;
                        w_issue2   = 1'b1;
                        pair_ready = 1'b1;
                    end else if (w_hz1) begin
                        w_issue1     = 1'b1;
                        pair_ready   = !valid2;
                        w_next_state = valid2 ? S_SECOND : S_PAIR;
                    end else begin
                        stall = 1'b1;
                    end
                end
                S_SECOND: begin
                    if (w_hz2) begin
                        w_issue2     = 1'b1;
                        pair_ready   = 1'b1;
                        w_next_state = S_PAIR;
                    end else begin
                        stall = 1'b1;
                    end
                end
                default: w_next_state = S_PAIR;
            endcase
        end
    end

    assign issue_even_valid = (w_issue1 && isEven1) || (w_issue2 && isEven2);
    assign issue_even_slot  = w_issue2 && isEven2;
    assign issue_odd_valid  = (w_issue1 && !isEven1) || (w_issue2 && !isEven2);
    assign issue_odd_slot   = w_issue2 && !isEven2;

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Directed and randomized bench for dual_issue_scheduler against a time-based readiness model.
module tb_dual_issue_scheduler;
    import spu_pkg::*;

    typedef struct {
        logic       even;
        logic [6:0] ra, rb, rc, rt;
        logic       ua, ub, uc, we;
        logic [3:0] lat;
    } instr_t;

    logic clk = 1'b0;
    logic rst_n, flush, pair_valid, valid2;
    instr_t s1, s2;
    logic pair_ready, issue_even_valid, issue_even_slot, issue_odd_valid, issue_odd_slot, stall;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int readyAt [NUM_REGS];
    bit second = 1'b0;
    bit expPr = 1'b0;

    always #5 clk = ~clk;

    dual_issue_scheduler dut (
        .clk (clk), .rst_n (rst_n), .flush (flush),
        .pair_valid (pair_valid), .valid2 (valid2),
        .isEven1 (s1.even), .isEven2 (s2.even),
        .readRegisterRA1 (s1.ra), .readRegisterRB1 (s1.rb),
        .readRegisterRC1 (s1.rc), .readRegisterRT1 (s1.rt),
        .readRegisterRA2 (s2.ra), .readRegisterRB2 (s2.rb),
        .readRegisterRC2 (s2.rc), .readRegisterRT2 (s2.rt),
        .useRA1 (s1.ua), .useRB1 (s1.ub), .useRC1 (s1.uc),
        .useRA2 (s2.ua), .useRB2 (s2.ub), .useRC2 (s2.uc),
        .regWriteEnable1 (s1.we), .regWriteEnable2 (s2.we),
        .latency1 (s1.lat), .latency2 (s2.lat),
        .pair_ready (pair_ready),
        .issue_even_valid (issue_even_valid), .issue_even_slot (issue_even_slot),
        .issue_odd_valid (issue_odd_valid), .issue_odd_slot (issue_odd_slot),
        .stall (stall)
    );

    function automatic instr_t mk(logic even, int ra, logic ua, int rb, logic ub,
                                  int rc, logic uc, int rt, logic we, int lat);
        instr_t x;
        x.even = even;
        x.ra = 7'(ra); x.rb = 7'(rb); x.rc = 7'(rc); x.rt = 7'(rt);
        x.ua = ua; x.ub = ub; x.uc = uc; x.we = we;
        x.lat = 4'(lat);
        return x;
    endfunction

    function automatic instr_t randInstr();
        return mk(1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 7)));
    endfunction

    // Cycles still to wait before register r may be read.
    function automatic int remaining(int r);
        return (readyAt[r] > cyc) ? readyAt[r] - cyc : 0;
    endfunction

    function automatic bit hazardFree(instr_t s);
        if (s.ua && remaining(int'(s.ra)) != 0) return 1'b0;
        if (s.ub && remaining(int'(s.rb)) != 0) return 1'b0;
        if (s.uc && remaining(int'(s.rc)) != 0) return 1'b0;
        if (s.we && remaining(int'(s.rt)) > int'(s.lat)) return 1'b0;
        return 1'b1;
    endfunction

    task automatic check(string tag, logic obs, logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(bit pv, bit v2, bit fl, instr_t a, instr_t b);
        pair_valid = pv;
        valid2     = v2;
        flush      = fl;
        s1         = a;
        s2         = b;
    endtask

    // Predicts this cycle's outputs, compares, then advances the model across the clock edge.
    task automatic checkOutput(string tag);
        bit i1, i2, raw, dual, ePr, eSt;
        i1 = 0; i2 = 0; ePr = 0; eSt = 0;
        #1;
        if (rst_n) begin
            if (flush) begin
                ePr = 1;
            end else if (pair_valid) begin
                if (!second) begin
                    raw  = s1.we && ((s2.ua && s2.ra == s1.rt) || (s2.ub && s2.rb == s1.rt) ||
                                     (s2.uc && s2.rc == s1.rt));
                    dual = valid2 && hazardFree(s1) && hazardFree(s2) && (s1.even != s2.even) &&
                           !raw && !(s1.we && s2.we && s1.rt == s2.rt);
                    if (dual) begin
                        i1 = 1; i2 = 1; ePr = 1;
                    end else if (hazardFree(s1)) begin
                        i1 = 1; ePr = !valid2;
                    end else begin
                        eSt = 1;
                    end
                end else if (hazardFree(s2)) begin
                    i2 = 1; ePr = 1;
                end else begin
                    eSt = 1;
                end
            end
        end
        check({tag, ".even_v"}, issue_even_valid, (i1 && s1.even) || (i2 && s2.even));
        check({tag, ".even_s"}, issue_even_slot, i2 && s2.even);
        check({tag, ".odd_v"}, issue_odd_valid, (i1 && !s1.even) || (i2 && !s2.even));
        check({tag, ".odd_s"}, issue_odd_slot, i2 && !s2.even);
        check({tag, ".ready"}, pair_ready, ePr);
        check({tag, ".stall"}, stall, eSt);
        expPr = ePr;
        @(posedge clk);
        if (rst_n) begin
            if (i1 && s1.we && s1.lat != 0) readyAt[s1.rt] = cyc + 1 + int'(s1.lat);
            if (i2 && s2.we && s2.lat != 0) readyAt[s2.rt] = cyc + 1 + int'(s2.lat);
            if (flush || i2) second = 1'b0;
            else if (i1 && valid2) second = 1'b1;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic runUntilReady(string tag, int bound);
        bit done;
        done = 0;
        for (int k = 0; k < bound && !done; k++) begin
            done = pair_ready;
            checkOutput(tag);
        end
        check({tag, ".bound"}, done, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        instr_t a, b, nop;
        bit hold;
        nop = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int r = 0; r < NUM_REGS; r++) readyAt[r] = 0;
        rst_n = 1'b0;
        applyStimulus(1, 1, 0, mk(1, 1, 1, 2, 1, 0, 0, 3, 1, 2), mk(0, 4, 1, 0, 0, 0, 0, 6, 0, 0));
        @(negedge clk);
        checkOutput("reset");
        rst_n = 1'b1;

        checkOutput("indep_pair");

        applyStimulus(1, 1, 0, mk(1, 1, 1, 0, 0, 0, 0, 7, 0, 0), mk(1, 2, 1, 0, 0, 0, 0, 8, 0, 0));
        checkOutput("both_even_c0");
        checkOutput("both_even_c1");

        applyStimulus(1, 1, 0, mk(1, 1, 1, 0, 0, 0, 0, 5, 1, 2), mk(0, 5, 1, 0, 0, 0, 0, 9, 0, 0));
        runUntilReady("intra_raw", 10);

        applyStimulus(1, 0, 0, mk(1, 0, 0, 0, 0, 0, 0, 10, 1, 6), nop);
        checkOutput("xraw_writer");
        applyStimulus(1, 0, 0, mk(0, 10, 1, 0, 0, 0, 0, 11, 0, 0), nop);
        runUntilReady("xraw_dep", 20);

        applyStimulus(1, 0, 0, mk(1, 0, 0, 0, 0, 0, 0, 20, 1, 5), nop);
        checkOutput("waw_first");
        applyStimulus(1, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 20, 1, 2), nop);
        runUntilReady("waw_second", 20);
        applyStimulus(1, 0, 0, mk(1, 20, 1, 0, 0, 0, 0, 21, 0, 0), nop);
        runUntilReady("waw_reader", 20);

        applyStimulus(1, 0, 0, mk(1, 0, 0, 0, 0, 0, 0, 30, 1, 7), nop);
        checkOutput("flush_writer");
        applyStimulus(1, 1, 0, mk(1, 1, 1, 0, 0, 0, 0, 31, 0, 0), mk(1, 30, 1, 0, 0, 0, 0, 32, 0, 0));
        checkOutput("flush_first");
        flush = 1'b1;
        checkOutput("flush_second");
        applyStimulus(1, 0, 0, mk(0, 30, 1, 0, 0, 0, 0, 33, 0, 0), nop);
        runUntilReady("flush_dep", 20);

        applyStimulus(1, 0, 0, mk(1, 0, 0, 0, 0, 0, 0, 40, 1, 9), nop);
        checkOutput("rst_writer");
        applyStimulus(1, 0, 0, mk(0, 40, 1, 0, 0, 0, 0, 41, 0, 0), nop);
        checkOutput("rst_stall");
        #2;
        rst_n = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) readyAt[r] = 0;
        second = 1'b0;
        checkOutput("rst_mid");
        rst_n = 1'b1;
        checkOutput("rst_dep");

        hold = 0;
        for (int n = 0; n < 400; n++) begin
            if (!hold) begin
                a = randInstr();
                b = randInstr();
                applyStimulus(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)),
                              1'($urandom_range(0, 19) == 0), a, b);
            end else begin
                flush = 1'($urandom_range(0, 14) == 0);
            end
            checkOutput("rand");
            hold = pair_valid && !expPr;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
